// File: rtl/bootrom_arbiter.sv
// Round-robin arbiter sharing the single-outstanding boot ROM port between NUM_REQ requesters.
// Out-of-window addresses and ROM timeouts complete with an error response.
module bootrom_arbiter #(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned ADDR_W        = 24,
    parameter int unsigned DATA_W        = 128,
    parameter int unsigned ROM_ADDR_BITS = 19,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_REQ-1:0]          resp_valid_o,
    output logic [DATA_W-1:0]           resp_data_o,
    output logic                        resp_err_o,
    output logic                        brom_req_valid_o,
    output logic [ADDR_W-1:0]           brom_req_address_o,
    input  logic                        brom_ready_i,
    input  logic [DATA_W-1:0]           brom_resp_data_i,
    input  logic                        brom_resp_valid_i,
    output logic                        busy_o
);

    localparam int unsigned GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT);
    localparam logic [GNT_W-1:0] LAST_RST = GNT_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [GNT_W-1:0]    gnt_q, gnt_d;
    logic [GNT_W-1:0]    last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [GNT_W-1:0]    sel;
    logic [GNT_W-1:0]    cand;
    logic                found;
    logic [ADDR_W-1:0]   sel_addr;
    logic                out_of_window;
    int unsigned         idx_u;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr_i[i*ADDR_W +: ADDR_W];
        end
    end

    // Round-robin pick: first valid requester after last_grant, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = last_q;
        cand  = '0;
        idx_u = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx_u = 32'(last_q) + k;
            if (idx_u >= NUM_REQ) begin
                idx_u = idx_u - NUM_REQ;
            end
            cand = GNT_W'(idx_u);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign sel_addr      = addr_arr[sel];
    assign out_of_window = (sel_addr >> ROM_ADDR_BITS) != '0;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            addr_q  <= '0;
            timer_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state, datapath updates and the two combinational strobes.
    always_comb begin
        state_d          = state_q;
        gnt_d            = gnt_q;
        last_d           = last_q;
        addr_d           = addr_q;
        timer_d          = timer_q;
        data_d           = data_q;
        err_d            = err_q;
        req_ready_o      = '0;
        brom_req_valid_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (found && !rst) begin
                    req_ready_o = NUM_REQ'(1) << sel;
                    gnt_d       = sel;
                    addr_d      = sel_addr;
                    if (out_of_window) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                brom_req_valid_o = brom_ready_i;
                if (brom_ready_i) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // A response arriving on the final cycle beats the timeout.
                if (brom_resp_valid_i) begin
                    data_d  = brom_resp_data_i;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                last_d  = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign resp_valid_o       = (state_q == S_RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
    assign resp_data_o        = data_q;
    assign resp_err_o         = err_q;
    assign brom_req_address_o = (state_q == S_ISSUE || state_q == S_WAIT) ? addr_q : '0;
    assign busy_o             = state_q != S_IDLE;

endmodule

// File: tb/tb_bootrom_arbiter.sv
// Directed bench for bootrom_arbiter: a transaction table plus hand-written reset sequences,
// driven against a latency-programmable ROM model.
module tb_bootrom_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid_i;
    logic [47:0]   req_addr_i;
    logic [1:0]    req_ready_o;
    logic [1:0]    resp_valid_o;
    logic [127:0]  resp_data_o;
    logic          resp_err_o;
    logic          brom_req_valid_o;
    logic [23:0]   brom_req_address_o;
    logic          brom_ready_i;
    logic [127:0]  brom_resp_data_i;
    logic          brom_resp_valid_i;
    logic          busy_o;

    bootrom_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_i        (req_valid_i),
        .req_addr_i         (req_addr_i),
        .req_ready_o        (req_ready_o),
        .resp_valid_o       (resp_valid_o),
        .resp_data_o        (resp_data_o),
        .resp_err_o         (resp_err_o),
        .brom_req_valid_o   (brom_req_valid_o),
        .brom_req_address_o (brom_req_address_o),
        .brom_ready_i       (brom_ready_i),
        .brom_resp_data_i   (brom_resp_data_i),
        .brom_resp_valid_i  (brom_resp_valid_i),
        .busy_o             (busy_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          pulse_cnt = 0;
    int          pulse_cyc = 0;
    int          rom_cnt = 0;
    int          rom_lat = 0;
    logic        rom_flush = 1'b0;
    logic [23:0] rom_addr = '0;

    function automatic logic [127:0] rom_data(input logic [23:0] a);
        return {8'h00, a, 32'hB007_0000, 8'hFF, ~a, 32'h0123_4567};
    endfunction

    // ROM model: a pulse arms a countdown; the response shows up L cycles after the pulse.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_flush) begin
            rom_cnt <= 0;
        end else if (brom_req_valid_o) begin
            pulse_cnt <= pulse_cnt + 1;
            pulse_cyc <= cyc;
            rom_addr  <= brom_req_address_o;
            rom_cnt   <= rom_lat;
        end else if (rom_cnt > 0) begin
            rom_cnt <= rom_cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] v, input logic [47:0] addrs, input logic rdy);
        req_valid_i       = v;
        req_addr_i        = addrs;
        brom_ready_i      = rdy;
        brom_resp_valid_i = (rom_cnt == 1);
        brom_resp_data_i  = rom_data(rom_addr);
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [23:0] a0;
        logic [23:0] a1;
        int          lat;
        int          rd;
        int          exp_g;
        logic        exp_err;
        int          exp_lat;
        int          exp_p;
    } txn_t;

    task automatic run_txn(input txn_t t, input string name);
        int          acc = -1;
        int          rsp = -1;
        int          g = -1;
        int          nrdy = 0;
        int          extra = 0;
        int          n = 0;
        int          k = 0;
        int          p0;
        logic [1:0]  rv = '0;
        logic [127:0] d = '0;
        logic        e = 1'b0;
        logic [23:0] exp_addr;
        exp_addr = (t.exp_g == 1) ? t.a1 : t.a0;
        p0 = pulse_cnt;
        rom_lat = t.lat;
        while (rsp < 0 && n < 100) begin
            @(negedge clk);
            set_in((acc < 0) ? t.valid : 2'b00, {t.a1, t.a0}, (acc < 0) || (cyc - acc > t.rd));
            #1;
            if (req_ready_o != 2'b00) begin
                nrdy++;
                if ($countones(req_ready_o) != 1) nrdy += 10;
                if (acc < 0) begin
                    acc = cyc;
                    g = req_ready_o[1] ? 1 : 0;
                end
            end
            if (resp_valid_o != 2'b00) begin
                rsp = cyc;
                rv  = resp_valid_o;
                d   = resp_data_o;
                e   = resp_err_o;
            end
            n++;
        end
        do begin
            @(negedge clk);
            set_in(2'b00, {t.a1, t.a0}, 1'b1);
            #1;
            if (resp_valid_o != 2'b00 || busy_o) extra++;
            k++;
        end while ((rom_cnt != 0 || k < 2) && k < 40);

        chk({name, " ready_strobes"}, 128'(nrdy), 128'(1));
        chk({name, " grant"}, 128'(g), 128'(t.exp_g));
        chk({name, " resp_seen"}, 128'(rsp >= 0), 128'(1));
        chk({name, " latency"}, 128'(rsp - acc), 128'(t.exp_lat));
        chk({name, " resp_vec"}, 128'(rv), 128'(2'b01 << t.exp_g));
        chk({name, " err"}, 128'(e), 128'(t.exp_err));
        chk({name, " data"}, d, t.exp_err ? 128'd0 : rom_data(exp_addr));
        chk({name, " pulses"}, 128'(pulse_cnt - p0), 128'(t.exp_p));
        if (t.exp_p == 1) begin
            chk({name, " pulse_addr"}, 128'(rom_addr), 128'(exp_addr));
            chk({name, " pulse_cycle"}, 128'(pulse_cyc - acc), 128'(t.rd + 1));
        end
        chk({name, " quiet_after_resp"}, 128'(extra), 128'(0));
    endtask

    txn_t vec [13];
    txn_t post_rst;

    initial begin
        //            valid  a0          a1          L   rd  g  err   lat pulses
        vec[0]  = '{2'b11, 24'h000100, 24'h000200, 2,  0,  0, 1'b0, 4,  1};
        vec[1]  = '{2'b11, 24'h000104, 24'h000204, 2,  0,  1, 1'b0, 4,  1};
        vec[2]  = '{2'b11, 24'h000108, 24'h000208, 3,  0,  0, 1'b0, 5,  1};
        vec[3]  = '{2'b11, 24'h00010C, 24'h00020C, 1,  0,  1, 1'b0, 3,  1};
        vec[4]  = '{2'b01, 24'h000010, 24'h000000, 5,  0,  0, 1'b0, 7,  1};
        vec[5]  = '{2'b10, 24'h000000, 24'h080000, 5,  0,  1, 1'b1, 1,  0};
        vec[6]  = '{2'b10, 24'h000000, 24'h07FFF0, 4,  0,  1, 1'b0, 6,  1};
        vec[7]  = '{2'b01, 24'hFFFFFF, 24'h000000, 4,  0,  0, 1'b1, 1,  0};
        vec[8]  = '{2'b01, 24'h000040, 24'h000000, 3,  3,  0, 1'b0, 8,  1};
        vec[9]  = '{2'b10, 24'h000000, 24'h000050, 16, 0,  1, 1'b0, 18, 1};
        vec[10] = '{2'b01, 24'h000060, 24'h000000, 0,  0,  0, 1'b1, 18, 1};
        vec[11] = '{2'b10, 24'h000000, 24'h000070, 18, 0,  1, 1'b1, 18, 1};
        vec[12] = '{2'b01, 24'h000080, 24'h000000, 1,  0,  0, 1'b0, 3,  1};
        post_rst = '{2'b11, 24'h000030, 24'h000040, 3, 0, 0, 1'b0, 5, 1};

        rst = 1'b1;
        rom_flush = 1'b1;
        set_in(2'b11, 48'h000020_000010, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("reset busy", 128'(busy_o), 128'(0));
        chk("reset req_ready", 128'(req_ready_o), 128'(0));
        chk("reset resp_valid", 128'(resp_valid_o), 128'(0));
        chk("reset brom_req_valid", 128'(brom_req_valid_o), 128'(0));
        chk("reset resp_err", 128'(resp_err_o), 128'(0));
        chk("reset resp_data", resp_data_o, 128'd0);
        @(negedge clk);
        set_in(2'b00, '0, 1'b1);
        rst = 1'b0;
        rom_flush = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_txn(vec[i], $sformatf("v%0d", i));
        end

        // Reset while waiting on the ROM: outputs clear at once, no response follows.
        rom_lat = 10;
        @(negedge clk);
        set_in(2'b01, 48'h000000_000020, 1'b1);
        #1;
        chk("rstwait accept", 128'(req_ready_o), 128'(2'b01));
        repeat (3) begin
            @(negedge clk);
            set_in(2'b00, 48'h000000_000020, 1'b1);
        end
        #1;
        chk("rstwait in_wait busy", 128'(busy_o), 128'(1));
        @(negedge clk);
        rst = 1'b1;
        rom_flush = 1'b1;
        #1;
        chk("rstwait busy", 128'(busy_o), 128'(0));
        chk("rstwait resp_valid", 128'(resp_valid_o), 128'(0));
        chk("rstwait resp_data", resp_data_o, 128'd0);
        chk("rstwait resp_err", 128'(resp_err_o), 128'(0));
        chk("rstwait brom_req_valid", 128'(brom_req_valid_o), 128'(0));
        chk("rstwait brom_addr", 128'(brom_req_address_o), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rom_flush = 1'b0;
        begin
            int stray = 0;
            repeat (12) begin
                @(negedge clk);
                set_in(2'b00, '0, 1'b1);
                #1;
                if (resp_valid_o != 2'b00 || busy_o) stray++;
            end
            chk("rstwait no_resp", 128'(stray), 128'(0));
        end
        run_txn(post_rst, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
